// File: rtl/mult_shift_seq.sv
// Multiply/shift order sequencer: a free-running digit counter times the gates
// so each order's active phase begins on an even minor-cycle d0 boundary.
module mult_shift_seq #(
    parameter int unsigned MC_LEN  = 36,
    parameter int unsigned MULT_MC = 17
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       op_mult,
    input  logic       op_shift,
    input  logic [5:0] shift_count,
    output logic       d0,
    output logic       d35,
    output logic       ev_d0,
    output logic       c5,
    output logic       c6,
    output logic       c7,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam int unsigned DCW     = (MC_LEN > 2) ? $clog2(MC_LEN) : 1;
    localparam int unsigned CNTW    = 6;
    localparam int unsigned MCW_MIN = $clog2(MULT_MC + 1);
    localparam int unsigned MCW     = (MCW_MIN > CNTW) ? MCW_MIN : CNTW;
    localparam logic [DCW-1:0] DC_LAST = DCW'(MC_LEN - 1);
    localparam logic [MCW-1:0] MC_MULT = MCW'(MULT_MC);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ALIGN = 2'd1,
        RUN   = 2'd2,
        TAIL  = 2'd3
    } state_t;

    logic [DCW-1:0]  dc_q;
    logic            par_q;
    state_t          state_q, state_d;
    logic [MCW-1:0]  mc_q, mc_d;
    logic            op_mult_q, op_mult_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic            c5_d, c6_d, c7_d, busy_d, done_d, err_d;

    // Digit counter and minor-cycle parity run regardless of the FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dc_q  <= '0;
            par_q <= 1'b0;
        end else if (dc_q == DC_LAST) begin
            dc_q  <= '0;
            par_q <= ~par_q;
        end else begin
            dc_q <= dc_q + DCW'(1);
        end
    end

    assign d0    = (dc_q == '0);
    assign d35   = (dc_q == DC_LAST);
    assign ev_d0 = d0 & ~par_q;

    // State and order registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            mc_q      <= '0;
            op_mult_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            mc_q      <= mc_d;
            op_mult_q <= op_mult_d;
            cnt_q     <= cnt_d;
        end
    end

    // Next state; ALIGN exits on an odd-parity d35 so the next clk is ev_d0
    always_comb begin
        state_d   = state_q;
        mc_d      = mc_q;
        op_mult_d = op_mult_q;
        cnt_d     = cnt_q;
        case (state_q)
            IDLE: begin
                if (start && (op_mult ^ op_shift)) begin
                    state_d   = ALIGN;
                    op_mult_d = op_mult;
                    cnt_d     = shift_count;
                end
            end
            ALIGN: begin
                if (d35 && par_q) begin
                    if (!op_mult_q && (cnt_q == '0)) begin
                        state_d = TAIL;
                    end else begin
                        state_d = RUN;
                        mc_d    = op_mult_q ? MC_MULT : MCW'(cnt_q);
                    end
                end
            end
            RUN: begin
                if (d35) begin
                    mc_d = mc_q - MCW'(1);
                    if (mc_q == MCW'(1)) begin
                        state_d = TAIL;
                    end
                end
            end
            TAIL: begin
                if (d35) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Gate values for the coming clk, derived from the next state
    always_comb begin
        c5_d   = 1'b0;
        c6_d   = 1'b0;
        c7_d   = 1'b0;
        busy_d = 1'b0;
        done_d = 1'b0;
        err_d  = 1'b0;
        c5_d   = (state_d == RUN) && op_mult_d;
        c6_d   = (state_d == RUN) && !op_mult_d;
        c7_d   = (state_d == TAIL);
        busy_d = (state_d != IDLE);
        done_d = (state_q == TAIL) && (state_d == IDLE);
        err_d  = (state_q == IDLE) && start && !(op_mult ^ op_shift);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c5   <= 1'b0;
            c6   <= 1'b0;
            c7   <= 1'b0;
            busy <= 1'b0;
            done <= 1'b0;
            err  <= 1'b0;
        end else begin
            c5   <= c5_d;
            c6   <= c6_d;
            c7   <= c7_d;
            busy <= busy_d;
            done <= done_d;
            err  <= err_d;
        end
    end

endmodule

// File: doc/mult_shift_seq.md
MULT_SHIFT_SEQ -- requirements
Module: mult_shift_seq

Interface
REQ-001 Parameter MC_LEN, default 36: pulse intervals (clk cycles) per minor cycle (M/C); digits d0..d(MC_LEN-1).
REQ-002 Parameter MULT_MC, default 17: number of RUN minor cycles for a multiply order.
REQ-003 Port clk, input, 1: pulse-interval clock; all state changes on the rising edge.
REQ-004 Port rst_n, input, 1: asynchronous active-low reset.
REQ-005 Port start, input, 1: order request, sampled only in IDLE.
REQ-006 Port op_mult, input, 1: selects a multiply order.
REQ-007 Port op_shift, input, 1: selects a shift order.
REQ-008 Port shift_count, input, 6: number of shift places (minor cycles), latched with start.
REQ-009 Port d0, output, 1: high when the digit counter is 0.
REQ-010 Port d35, output, 1: high when the digit counter is MC_LEN-1.
REQ-011 Port ev_d0, output, 1: d0 qualified by even minor-cycle parity.
REQ-012 Port c5, output, 1: multiply gate, high throughout RUN of a multiply.
REQ-013 Port c6, output, 1: shift gate, high throughout RUN of a shift.
REQ-014 Port c7, output, 1: collation gate, high throughout TAIL.
REQ-015 Port busy, output, 1: high in every state except IDLE.
REQ-016 Port done, output, 1: one-clk pulse at order completion.
REQ-017 Port err, output, 1: one-clk pulse on an illegal start.

Function
REQ-018 Digit counter free-runs 0..MC_LEN-1 and wraps to 0; it is never stopped by the FSM.
REQ-019 Parity bit toggles on every wrap from MC_LEN-1 to 0.
REQ-020 d0, d35 and ev_d0 are decoded combinationally from the counter and parity, with no added latency.
REQ-021 States: IDLE, ALIGN, RUN, TAIL.
REQ-022 IDLE: start with exactly one of op_mult/op_shift goes to ALIGN and latches the op and shift_count.
REQ-023 IDLE: start with both or neither op bit pulses err for one clk and stays in IDLE.
REQ-024 start outside IDLE is ignored: no latch, no err.
REQ-025 ALIGN: wait for the clk where d35 is high and parity=1, so the next clk is ev_d0.
REQ-026 ALIGN exit, shift with count 0: go to TAIL.
REQ-027 ALIGN exit, all other orders: go to RUN; the minor-cycle counter loads MULT_MC (multiply) or the latched count (shift).
REQ-028 RUN: decrement the minor-cycle counter at each d35; at d35 with counter=1, go to TAIL.
REQ-029 RUN length is therefore exactly N×MC_LEN clks.
REQ-030 TAIL: lasts exactly one minor cycle; at its d35, pulse done on the following clk (first clk of IDLE) and enter IDLE.
REQ-031 Gating: c5 high only in RUN with op=mult; c6 high only in RUN with op=shift; c7 high only in TAIL.
REQ-032 All gates (c5, c6, c7, done, err, busy) are registered outputs.
REQ-033 A start in the same clk that done pulses is accepted, because the FSM is already in IDLE.
REQ-034 Latched op and count do not change during busy.

Reset
REQ-035 While rst_n=0: digit counter=0, parity=0, FSM=IDLE, minor-cycle counter=0, and c5, c6, c7, busy, done, err are all 0.
REQ-036 Assertion of rst_n mid-operation aborts immediately with no done pulse.
REQ-037 After rst_n deasserts, the first clk edge shows counter=0, so d0=ev_d0=1.

Verification
REQ-038 Reset release with no start -> d0/ev_d0 high at clk 0; d35 at clk 35; d0 with ev_d0=0 at clk 36; ev_d0 again at clk 72.
REQ-039 Shift, count=3, start at digit 5 of M/C 0 -> RUN begins at M/C 2 d0 (clk 72); c6 high clks 72-179; c7 high clks 180-215; done at clk 216.
REQ-040 Multiply, default MULT_MC=17 -> c5 high for exactly 612 clks starting on an ev_d0; c6 stays 0; then 36 clks of c7; then done.
REQ-041 Shift, count=0 -> no c6 at all; one M/C of c7 starting on ev_d0; then done.
REQ-042 start with op_mult=op_shift=1 -> err for 1 clk, busy stays 0; a second start during busy is ignored.
REQ-043 rst_n pulsed low during RUN -> all gates 0 immediately, no done, and the digit counter restarts at 0.
